hls_array_bank: RTL and testbench

Parametrised backing store for the array ports of a generated kernel (`main`): WIDTH-bit words, DEPTH entries, NPORTS independent kernel ports (WEnable/Addr/WData/RData per port).
It replaces the undriven array wiring in simulation tops.
It adds a host load/dump port and a run-state FSM that tracks kernel start (r_enable) and completion (w_enable), so the host can preload inputs and read back results.
It is synthesisable and sits between the kernel and the harness.

---
 rtl/hls_array_pkg.sv | 17 +
 rtl/hls_array_wsel.sv | 31 +++
 rtl/hls_array_bank.sv | 130 +++++++++++++
 tb/tb_hls_array_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_array_pkg.sv
// Shared types and helpers for the hls_array_bank backing store.
package hls_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int RUN_CNT_W = 32;

  // Address width never drops below one bit, even for a single-entry bank.
  function automatic int calc_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hls_array_wsel.sv
// Per-entry write arbiter: picks the lowest-index kernel port writing each entry.
module hls_array_wsel #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 2,
  parameter int NPORTS = 2,
  parameter int AW     = 1
) (
  input  logic                    en,
  input  logic [NPORTS-1:0]       wenable,
  input  logic [NPORTS*AW-1:0]    addr,
  input  logic [NPORTS*WIDTH-1:0] wdata,
  output logic [DEPTH-1:0]        word_we,
  output logic [DEPTH*WIDTH-1:0]  word_wdata
);

  // Walking from the highest port down lets the lowest index overwrite last.
  // Addresses >= DEPTH never match an entry, so those writes vanish here.
  always_comb begin
    word_we    = '0;
    word_wdata = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = NPORTS - 1; p >= 0; p--) begin
        if (en && wenable[p] && (int'(addr[p*AW +: AW]) == a)) begin
          word_we[a]                  = 1'b1;
          word_wdata[a*WIDTH +: WIDTH] = wdata[p*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/hls_array_bank.sv
// Kernel array backing store with host load/dump port and IDLE/RUN/DONE run tracking.
// Optional run-cycle counter output enabled by HLS_ARRAY_BANK_CYCLE_COUNT_EN.
//
// Handshake: host_req is a level held by the host; a request is taken on an edge
// where host_req=1, state!=RUN and host_ack=0, and host_ack pulses for exactly the
// following cycle (with host_rdata valid for reads). Kernel ports carry no handshake.
module hls_array_bank
  import hls_array_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 2,
  parameter int NPORTS     = 2,
  parameter int READ_FIRST = 1,
  localparam int AW        = calc_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    r_enable,
  input  logic                    w_enable,
  input  logic [NPORTS-1:0]       arr_wenable,
  input  logic [NPORTS*AW-1:0]    arr_addr,
  input  logic [NPORTS*WIDTH-1:0] arr_wdata,
  output logic [NPORTS*WIDTH-1:0] arr_rdata,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [AW-1:0]           host_addr,
  input  logic [WIDTH-1:0]        host_wdata,
  output logic [WIDTH-1:0]        host_rdata,
  output logic                    host_ack,
  output logic                    busy,
  output logic [1:0]              dbg_state
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
  ,
  output logic [RUN_CNT_W-1:0]    run_cycles
`endif
);

  state_e state, state_nxt;
  logic   run;
  logic   host_acc;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]        word_we;
  logic [DEPTH*WIDTH-1:0]  word_wdata;
  logic [NPORTS*WIDTH-1:0] kread;
  logic [WIDTH-1:0]        hread;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // w_enable dominates in RUN, so a simultaneous r_enable still ends the run.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (r_enable) state_nxt = RUN;
      RUN:        if (w_enable) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign run       = (state == RUN);
  assign busy      = run;
  assign dbg_state = state;
  assign host_acc  = host_req && !run && !host_ack;

  hls_array_wsel #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NPORTS(NPORTS),
    .AW    (AW)
  ) u_wsel (
    .en        (run),
    .wenable   (arr_wenable),
    .addr      (arr_addr),
    .wdata     (arr_wdata),
    .word_we   (word_we),
    .word_wdata(word_wdata)
  );

  // Out-of-range addresses match no entry and therefore read as zero.
  always_comb begin
    kread = '0;
    hread = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (int'(arr_addr[p*AW +: AW]) == a) begin
          if (READ_FIRST == 0 && word_we[a]) kread[p*WIDTH +: WIDTH] = word_wdata[a*WIDTH +: WIDTH];
          else                               kread[p*WIDTH +: WIDTH] = mem[a];
        end
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (int'(host_addr) == a) hread = mem[a];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      arr_rdata  <= '0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
    end else begin
      host_ack <= host_acc;
      if (host_acc && !host_we) host_rdata <= hread;
      if (run)                  arr_rdata  <= kread;
      // Kernel and host writes never coincide: the host is only served outside RUN.
      for (int a = 0; a < DEPTH; a++) begin
        if (word_we[a])
          mem[a] <= word_wdata[a*WIDTH +: WIDTH];
        else if (host_acc && host_we && (int'(host_addr) == a))
          mem[a] <= host_wdata;
      end
    end
  end

`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      run_cycles <= '0;
    else if (!run && state_nxt == RUN)
      run_cycles <= '0;
    else if (run && run_cycles != '1)
      run_cycles <= run_cycles + RUN_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_hls_array_bank.sv
// Directed bench for hls_array_bank: a default instance plus a DEPTH=3 READ_FIRST=0 instance.
module tb_hls_array_bank;
  import hls_array_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         r_en, w_en;
  logic [1:0]   k_we;
  logic [1:0]   k_addr;
  logic [127:0] k_wdata, k_rdata;
  logic         h_req, h_we, h_ack, busy;
  logic [0:0]   h_addr;
  logic [63:0]  h_wdata, h_rdata;
  logic [1:0]   dbg;

  logic         r_en3, w_en3;
  logic [1:0]   k_we3;
  logic [3:0]   k_addr3;
  logic [31:0]  k_wdata3, k_rdata3;
  logic         h_req3, h_we3, h_ack3, busy3;
  logic [1:0]   h_addr3;
  logic [15:0]  h_wdata3, h_rdata3;
  logic [1:0]   dbg3;
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
  logic [31:0]  cyc, cyc3;
`endif

  hls_array_bank u_dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_en), .w_enable(w_en),
    .arr_wenable(k_we), .arr_addr(k_addr), .arr_wdata(k_wdata), .arr_rdata(k_rdata),
    .host_req(h_req), .host_we(h_we), .host_addr(h_addr), .host_wdata(h_wdata),
    .host_rdata(h_rdata), .host_ack(h_ack), .busy(busy), .dbg_state(dbg)
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    , .run_cycles(cyc)
`endif
  );

  hls_array_bank #(.WIDTH(16), .DEPTH(3), .NPORTS(2), .READ_FIRST(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_en3), .w_enable(w_en3),
    .arr_wenable(k_we3), .arr_addr(k_addr3), .arr_wdata(k_wdata3), .arr_rdata(k_rdata3),
    .host_req(h_req3), .host_we(h_we3), .host_addr(h_addr3), .host_wdata(h_wdata3),
    .host_rdata(h_rdata3), .host_ack(h_ack3), .busy(busy3), .dbg_state(dbg3)
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    , .run_cycles(cyc3)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] rd;
  int lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until ack (bounded), then release and let ack fall.
  task automatic host_op(input logic we, input logic [0:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output int cycles);
    h_we = we; h_addr = addr; h_wdata = wdata; h_req = 1'b1;
    cycles = 0;
    do begin tick(); cycles++; end while (!h_ack && cycles < 8);
    rdata = h_rdata;
    h_req = 1'b0;
    tick();
  endtask

  task automatic host_op3(input logic we, input logic [1:0] addr, input logic [15:0] wdata,
                          output logic [63:0] rdata, output int cycles);
    h_we3 = we; h_addr3 = addr; h_wdata3 = wdata; h_req3 = 1'b1;
    cycles = 0;
    do begin tick(); cycles++; end while (!h_ack3 && cycles < 8);
    rdata = 64'(h_rdata3);
    h_req3 = 1'b0;
    tick();
  endtask

  initial begin
    r_en = 0; w_en = 0; k_we = 0; k_addr = 0; k_wdata = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    r_en3 = 0; w_en3 = 0; k_we3 = 0; k_addr3 = 0; k_wdata3 = 0;
    h_req3 = 0; h_we3 = 0; h_addr3 = 0; h_wdata3 = 0;

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(h_ack), 64'd0);
    chk("rst_krdata", k_rdata[63:0] | k_rdata[127:64], 64'd0);
    chk("rst_hrdata", h_rdata, 64'd0);
    chk("rst_state", 64'(dbg), 64'(IDLE));
    rst_n = 1'b1;
    tick();

    // Host preload in IDLE
    host_op(1'b1, 1'b0, 64'hffff_ffff_ffff_fff9, rd, lat);
    chk("hwr_lat", 64'(lat), 64'd1);
    host_op(1'b1, 1'b1, 64'd3, rd, lat);
    host_op(1'b0, 1'b0, 64'd0, rd, lat);
    chk("hrd_lat", 64'(lat), 64'd1);
    chk("hrd_data", rd, 64'hffff_ffff_ffff_fff9);
    chk("idle_busy", 64'(busy), 64'd0);

    // Held request: ack, gap, ack
    h_req = 1; h_we = 0; h_addr = 1;
    tick();
    chk("hold_ack1", 64'(h_ack), 64'd1);
    chk("hold_data", h_rdata, 64'd3);
    tick();
    chk("hold_no_reaccept", 64'(h_ack), 64'd0);
    tick();
    chk("hold_ack2", 64'(h_ack), 64'd1);
    h_req = 0;
    tick();

    // Run gating with a stalled host read of addr0
    r_en = 1; tick(); r_en = 0;
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_state", 64'(dbg), 64'(RUN));
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("cyc_entry", 64'(cyc), 64'd0);
`endif
    h_req = 1; h_we = 0; h_addr = 0;

    // Both ports write addr1; port1 also reads addr1
    k_we = 2'b11; k_addr = {1'b1, 1'b1}; k_wdata = {64'd9, 64'd5};
    tick();
    chk("rf1_old", k_rdata[127:64], 64'd3);
    chk("stall_ack_a", 64'(h_ack), 64'd0);
    k_we = 2'b00; k_addr = {1'b1, 1'b0};
    tick();
    chk("lat_p0_a0", k_rdata[63:0], 64'hffff_ffff_ffff_fff9);
    chk("conflict_p0_wins", k_rdata[127:64], 64'd5);
    k_addr = {1'b1, 1'b1};
    tick();
    chk("lat_p0_a1", k_rdata[63:0], 64'd5);
    chk("stall_ack_b", 64'(h_ack), 64'd0);
    r_en = 1; tick(); r_en = 0;
    chk("r_in_run_ignored", 64'(dbg), 64'(RUN));
    w_en = 1; tick(); w_en = 0;
    chk("done_state", 64'(dbg), 64'(DONE));
    chk("done_busy", 64'(busy), 64'd0);
    chk("no_ack_on_done_edge", 64'(h_ack), 64'd0);
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("cyc_run5", 64'(cyc), 64'd5);
`endif
    tick();
    chk("stalled_ack", 64'(h_ack), 64'd1);
    chk("stalled_data", h_rdata, 64'hffff_ffff_ffff_fff9);
    h_req = 0;
    tick();
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("cyc_frozen5", 64'(cyc), 64'd5);
`endif

    // Kernel write in DONE is dropped, rdata holds
    k_we = 2'b01; k_addr = 2'b00; k_wdata = {64'd0, 64'd42};
    tick();
    k_we = 2'b00;
    chk("rdata_hold", k_rdata[63:0], 64'd5);
    host_op(1'b0, 1'b0, 64'd0, rd, lat);
    chk("done_write_dropped", rd, 64'hffff_ffff_ffff_fff9);

    // Ten-cycle run from DONE
    r_en = 1; tick(); r_en = 0;
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("cyc_restart_clear", 64'(cyc), 64'd0);
`endif
    tick();
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("cyc_first", 64'(cyc), 64'd1);
`endif
    repeat (8) tick();
    w_en = 1; tick(); w_en = 0;
    chk("run10_done", 64'(dbg), 64'(DONE));
    tick(); tick();
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("cyc_run10", 64'(cyc), 64'd10);
`endif

    // Reset mid-run
    r_en = 1; tick(); r_en = 0;
    k_addr = 2'b00;
    tick(); tick();
    chk("pre_rst_rdata", k_rdata[63:0], 64'hffff_ffff_ffff_fff9);
    rst_n = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_state", 64'(dbg), 64'(IDLE));
    chk("midrst_rdata", k_rdata[63:0], 64'd0);
`ifdef HLS_ARRAY_BANK_CYCLE_COUNT_EN
    chk("midrst_cyc", 64'(cyc), 64'd0);
`endif
    #3;
    rst_n = 1;
    tick();
    host_op(1'b0, 1'b0, 64'd0, rd, lat);
    chk("mem0_cleared", rd, 64'd0);
    host_op(1'b0, 1'b1, 64'd0, rd, lat);
    chk("mem1_cleared", rd, 64'd0);

    // DEPTH=3, READ_FIRST=0 instance
    host_op3(1'b1, 2'd3, 16'h1234, rd, lat);
    chk("oor_wr_ack", 64'(lat), 64'd1);
    host_op3(1'b0, 2'd3, 16'h0, rd, lat);
    chk("oor_host_rd", rd, 64'd0);
    host_op3(1'b1, 2'd2, 16'h00aa, rd, lat);
    host_op3(0, 2'd2, 16'h0, rd, lat);
    chk("top_entry_rd", rd, 64'h00aa);
    host_op3(1'b1, 2'd1, 16'h0007, rd, lat);
    r_en3 = 1; tick(); r_en3 = 0;
    k_we3 = 2'b11; k_addr3 = {2'd1, 2'd1}; k_wdata3 = {16'h0022, 16'h0011};
    tick();
    chk("rf0_forward", 64'(k_rdata3[31:16]), 64'h0011);
    k_we3 = 2'b01; k_addr3 = {2'd1, 2'd3}; k_wdata3 = {16'h0, 16'h0055};
    tick();
    k_we3 = 2'b00;
    chk("oor_kernel_rd", 64'(k_rdata3[15:0]), 64'd0);
    chk("p1_after_conflict", 64'(k_rdata3[31:16]), 64'h0011);
    w_en3 = 1; tick(); w_en3 = 0;
    host_op3(1'b0, 2'd1, 16'h0, rd, lat);
    chk("dut3_mem1", rd, 64'h0011);
    host_op3(1'b0, 2'd3, 16'h0, rd, lat);
    chk("oor_kernel_wr_ignored", rd, 64'd0);
    host_op3(1'b0, 2'd2, 16'h0, rd, lat);
    chk("dut3_mem2_kept", rd, 64'h00aa);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
